// File: rtl/dpram_port_arbiter.sv
// Round-robin req/ack arbiter sharing one port of a 128x8 dual-port RAM between two requesters.
// Optional post-reset zero-fill of the RAM when DPRAM_ARB_CLEAR_EN is defined.
module dpram_port_arbiter #(
  parameter int                ADDR_W      = 7,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic              ram_byteena,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {ST_CLEAR, ST_FIN, ST_RUN} state_t;

`ifdef DPRAM_ARB_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;
  logic              last_q;
  logic              ack0_q, ack1_q;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              pipe_vld_q, pipe_id_q;
  logic              rv0_q, rv1_q;

  logic elig0_d, elig1_d, gnt0_d, gnt1_d, rd_issue_d;

  // A requester just acked is masked so its still-held req is not issued twice.
  assign elig0_d    = r0_req & ~ack0_q;
  assign elig1_d    = r1_req & ~ack1_q;
  assign gnt0_d     = (state_q == ST_RUN) & elig0_d & (~elig1_d | last_q);
  assign gnt1_d     = (state_q == ST_RUN) & elig1_d & (~elig0_d | ~last_q);
  assign rd_issue_d = (gnt0_d & ~r0_we) | (gnt1_d & ~r1_we);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      last_q     <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      pipe_vld_q <= 1'b0;
      pipe_id_q  <= 1'b0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      ack0_q     <= gnt0_d;
      ack1_q     <= gnt1_d;
      // RAM samples at the end of the ack cycle; ram_q is valid one cycle later.
      pipe_vld_q <= rd_issue_d;
      pipe_id_q  <= gnt1_d;
      rv0_q      <= pipe_vld_q & ~pipe_id_q;
      rv1_q      <= pipe_vld_q & pipe_id_q;
      case (state_q)
        ST_CLEAR: begin
          wren_q <= 1'b1;
          addr_q <= cnt_q;
          data_q <= CLEAR_VALUE;
          cnt_q  <= cnt_q + CNT_ONE;
          if (cnt_q == '1) state_q <= ST_FIN;
        end
        ST_FIN: begin
          wren_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_RUN;
        end
        default: begin
          ready_q <= 1'b1;
          if (gnt0_d) begin
            addr_q <= r0_addr;
            data_q <= r0_wdata;
            wren_q <= r0_we;
            last_q <= 1'b0;
          end else if (gnt1_d) begin
            addr_q <= r1_addr;
            data_q <= r1_wdata;
            wren_q <= r1_we;
            last_q <= 1'b1;
          end else begin
            wren_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign r0_ack      = ack0_q;
  assign r1_ack      = ack1_q;
  assign r0_rvalid   = rv0_q;
  assign r1_rvalid   = rv1_q;
  assign r0_rdata    = rv0_q ? ram_q : '0;
  assign r1_rdata    = rv1_q ? ram_q : '0;
  assign ram_addr    = addr_q;
  assign ram_wren    = wren_q;
  assign ram_byteena = 1'b1;
  assign ram_data    = data_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural RAM, transaction-level reference model, random + directed traffic.
module tb_dpram_port_arbiter;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 128;
`ifdef DPRAM_ARB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_t  [2];
  logic          we_t   [2];
  logic [AW-1:0] addr_t [2];
  logic [DW-1:0] wdat_t [2];

  logic          ready, r0_ack, r0_rvalid, r1_ack, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata, ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_wren, ram_byteena;
  logic [DW-1:0] ram_q = '0;

  dpram_port_arbiter dut (
    .clk(clk), .reset(reset), .ready(ready),
    .r0_req(req_t[0]), .r0_we(we_t[0]), .r0_addr(addr_t[0]), .r0_wdata(wdat_t[0]),
    .r0_ack(r0_ack), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(req_t[1]), .r1_we(we_t[1]), .r1_addr(addr_t[1]), .r1_wdata(wdat_t[1]),
    .r1_ack(r1_ack), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteena(ram_byteena),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  // RAM with registered read and a side door for preloading
  logic [DW-1:0] ram_mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_dat = '0;
  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_addr] <= pre_dat;
    else if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents, who was acked last cycle, last winner, outstanding read
  logic [DW-1:0] ref_mem [DEPTH];
  int            edge_n;
  bit            m_ack [2];
  int            m_last;
  bit            pend_vld;
  int            pend_id;
  logic [DW-1:0] pend_dat;

  bit            obs_ack [2];
  bit            obs_rv [2];
  logic [DW-1:0] obs_rdat [2];

  task automatic model_reset();
    edge_n = 0; m_ack[0] = 0; m_ack[1] = 0; m_last = 1; pend_vld = 0; pend_id = 0; pend_dat = '0;
    if (CLR) for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
  endtask

  // One clock: predict from the inputs the edge will sample, advance, compare at the negedge.
  task automatic step();
    bit elig [2];
    bit arb_on, x_ready, x_wren, chk_ram;
    bit x_rv [2];
    int g;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data, x_rdat;
    edge_n++;
    arb_on  = CLR ? (edge_n >= DEPTH + 2) : 1'b1;
    x_ready = CLR ? (edge_n >= DEPTH + 1) : 1'b1;
    for (int i = 0; i < 2; i++) elig[i] = req_t[i] && !m_ack[i];
    g = -1;
    if (arb_on) begin
      if (elig[0] && elig[1]) g = (m_last == 1) ? 0 : 1;
      else if (elig[0]) g = 0;
      else if (elig[1]) g = 1;
    end
    x_rv[0] = pend_vld && pend_id == 0;
    x_rv[1] = pend_vld && pend_id == 1;
    x_rdat  = pend_dat;
    chk_ram = 1'b1; x_addr = '0; x_data = '0; x_wren = 1'b0;
    if (CLR && edge_n <= DEPTH) begin
      x_wren = 1'b1; x_addr = AW'(edge_n - 1); x_data = '0;
    end else if (g >= 0) begin
      x_wren = we_t[g]; x_addr = addr_t[g]; x_data = wdat_t[g];
    end else begin
      chk_ram = 1'b0;
    end
    pend_vld = 1'b0;
    if (g >= 0) begin
      pend_vld = !we_t[g];
      pend_id  = g;
      pend_dat = ref_mem[addr_t[g]];
      if (we_t[g]) ref_mem[addr_t[g]] = wdat_t[g];
      m_last = g;
    end
    m_ack[0] = (g == 0);
    m_ack[1] = (g == 1);

    @(posedge clk);
    @(negedge clk);
    obs_ack[0] = r0_ack;      obs_ack[1] = r1_ack;
    obs_rv[0]  = r0_rvalid;   obs_rv[1]  = r1_rvalid;
    obs_rdat[0] = r0_rdata;   obs_rdat[1] = r1_rdata;
    check("r0_ack", r0_ack, m_ack[0]);
    check("r1_ack", r1_ack, m_ack[1]);
    check("r0_rvalid", r0_rvalid, x_rv[0]);
    check("r1_rvalid", r1_rvalid, x_rv[1]);
    if (x_rv[0]) check("r0_rdata", r0_rdata, x_rdat);
    if (x_rv[1]) check("r1_rdata", r1_rdata, x_rdat);
    check("ready", ready, x_ready);
    check("ram_wren", ram_wren, x_wren);
    if (chk_ram) begin
      check("ram_addr", ram_addr, x_addr);
      check("ram_data", ram_data, x_data);
    end
  endtask

  task automatic set_cmd(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t[i] = 1'b1; we_t[i] = we; addr_t[i] = a; wdat_t[i] = d;
  endtask

  task automatic rand_cmd(input int i);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
    set_cmd(i, ($urandom_range(0, 1) == 1), a, DW'($urandom));
  endtask

  // Present a command and step until it is acked (bounded), then drop req.
  task automatic issue(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    set_cmd(i, we, a, d);
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      done = m_ack[i];
    end
    if (!done) check("ack_wait", (i == 0) ? r0_ack : r1_ack, 1);
    req_t[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_acks"}, {r0_ack, r1_ack}, 0);
    check({tag, "_rvalids"}, {r0_rvalid, r1_rvalid}, 0);
    check({tag, "_rdata"}, {r0_rdata, r1_rdata}, 0);
    check({tag, "_wren"}, ram_wren, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_data"}, ram_data, 0);
    check({tag, "_byteena"}, ram_byteena, 1);
  endtask

  initial begin
    int first_ack, cnt0, cnt1;
    bit got0, got1;
    logic [DW-1:0] v;
    for (int i = 0; i < 2; i++) begin
      req_t[i] = 0; we_t[i] = 0; addr_t[i] = '0; wdat_t[i] = '0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      case (a)
        'h05: v = 8'hA5;
        'h10: v = 8'h11;
        'h20: v = 8'h22;
        'h55: v = 8'h5A;
        default: v = DW'($urandom);
      endcase
      @(negedge clk);
      pre_we = 1'b1; pre_addr = AW'(a); pre_dat = v; ref_mem[a] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;
    check_reset_outputs("rst");

    // Contention straight out of reset (clear sweep runs first when enabled)
    set_cmd(0, 1'b0, 7'h10, '0);
    set_cmd(1, 1'b0, 7'h20, '0);
    reset = 1'b0;
    model_reset();
    check("ready_pre_edge", ready, 0);
    first_ack = -1; got0 = 0; got1 = 0;
    for (int c = 0; c < 300 && !(got0 && got1); c++) begin
      step();
      if (obs_ack[0] && first_ack < 0) first_ack = 0;
      if (obs_ack[1] && first_ack < 0) first_ack = 1;
      if (m_ack[0]) begin got0 = 1; req_t[0] = 0; end
      if (m_ack[1]) begin got1 = 1; req_t[1] = 0; end
    end
    check("first_ack_r0", first_ack, 0);
    check("contention_r0_rv", obs_rv[0], 1);
    check("contention_r0_data", obs_rdat[0], CLR ? 8'h00 : 8'h11);
    step();
    check("contention_r1_rv", obs_rv[1], 1);
    check("contention_r1_data", obs_rdat[1], CLR ? 8'h00 : 8'h22);

    // Single read
    issue(0, 1'b0, 7'h05, '0);
    step();
    check("single_rv", obs_rv[0], 1);
    check("single_data", obs_rdat[0], CLR ? 8'h00 : 8'hA5);
    check("single_no_r1", obs_rv[1], 0);

    issue(0, 1'b0, 7'h55, '0);
    step();
    check("read55_data", obs_rdat[0], CLR ? 8'h00 : 8'h5A);

    // Fairness: both keep requesting
    set_cmd(0, 1'b0, AW'($urandom), '0);
    set_cmd(1, 1'b0, AW'($urandom), '0);
    step();
    cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_ack[0]) set_cmd(0, 1'b0, AW'($urandom), '0);
      if (m_ack[1]) set_cmd(1, 1'b0, AW'($urandom), '0);
      step();
      cnt0 += int'(obs_ack[0]);
      cnt1 += int'(obs_ack[1]);
    end
    check("fair_r0", cnt0, 4);
    check("fair_r1", cnt1, 4);
    req_t[0] = 0; req_t[1] = 0;
    repeat (3) step();

    // Write-then-read by one requester
    issue(1, 1'b1, 7'h7F, 8'h3C);
    step();
    check("wr_no_rvalid", obs_rv[1], 0);
    issue(1, 1'b0, 7'h7F, '0);
    step();
    check("rdback_rv", obs_rv[1], 1);
    check("rdback_data", obs_rdat[1], 8'h3C);

    // Back-to-back write (r0) then read (r1) of the same address
    set_cmd(0, 1'b1, 7'h30, 8'h77);
    set_cmd(1, 1'b0, 7'h30, '0);
    step();
    req_t[0] = 0;
    step();
    req_t[1] = 0;
    step();
    check("raw_rv", obs_rv[1], 1);
    check("raw_data", obs_rdat[1], 8'h77);

    // Reset asserted in the ack cycle of a read
    issue(0, 1'b0, 7'h05, '0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("midrst_no_rv", r0_rvalid, 0);
    end
    reset = 1'b0;
    model_reset();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (m_ack[i] || !req_t[i]) begin
          if ($urandom_range(0, 1) == 1) rand_cmd(i);
          else req_t[i] = 1'b0;
        end
      end
    end
    req_t[0] = 0; req_t[1] = 0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one port of the 128x8 dual-port RAM between two requesters (e.g. CPU-side register file and a DMA/OAM engine).
- Round-robin arbitration with a req/ack handshake; read data returns with a fixed latency.
- Drives registered address, write-enable and data onto the RAM port and tracks the RAM's 1-cycle read latency.
- Optional post-reset clear engine zero-fills the RAM before the first grant.

Parameters:
- ADDR_W, 7, RAM address width (depth = 2**ADDR_W)
- DATA_W, 8, RAM data width
- CLEAR_VALUE, 8'h00, fill value used by the clear engine

Ports:
- clk  in  1  single clock for the block and the RAM port
- reset  in  1  asynchronous, active-high reset
- ready  out  1  high when arbitration is running
- r0_req  in  1  requester 0 request; held with r0_we/r0_addr/r0_wdata stable until r0_ack
- r0_we  in  1  1=write, 0=read
- r0_addr  in  ADDR_W  requester 0 address
- r0_wdata  in  DATA_W  requester 0 write data
- r0_ack  out  1  1-cycle pulse: command issued to RAM this cycle
- r0_rvalid  out  1  1-cycle pulse: read data on r0_rdata
- r0_rdata  out  DATA_W  read data, valid only with r0_rvalid
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rvalid, r1_rdata: same as requester 0
- ram_addr  out  ADDR_W  to RAM port address
- ram_wren  out  1  to RAM port write enable
- ram_byteena  out  1  constant 1
- ram_data  out  DATA_W  to RAM port write data
- ram_q  in  DATA_W  RAM port registered read data

Behaviour:
- Reset: all outputs 0 (ram_byteena 1); round-robin pointer last=1, so r0 wins the first tie; state per Optional Feature.
- Eligibility: rN is eligible when rN_req=1 AND rN_ack=0 in the current cycle. The acked requester is masked for one cycle, so its held req is never issued twice.
- Arbitration (state RUN), evaluated each rising edge:
  - Neither eligible: ram_wren<=0; ram_addr and ram_data hold.
  - One eligible: grant it.
  - Both eligible: grant the requester opposite to last.
- Grant of rN, registered at edge E:
  - ram_addr<=rN_addr, ram_data<=rN_wdata, ram_wren<=rN_we, rN_ack<=1, last<=N.
  - Requester may drop req or present a new command in the ack cycle. That command is eligible from the next cycle.
- Read latency:
  - Ack in cycle T means the RAM samples at the end of T, and ram_q is valid in T+1.
  - rN_rvalid pulses in T+1 only for reads. A 1-deep pipe register stores {valid, id}.
  - r0_rdata and r1_rdata are both driven from ram_q.
- Throughput: one command per cycle with both requesters active (alternating); one per 2 cycles for a single requester.
- Writes: ack only, no rvalid.
- Read-after-write to the same address, issued in consecutive cycles: returns the new data. The RAM write commits before the next read sample.
- Reset mid-operation: pending acks and rvalids are discarded; pipe cleared; clear restarts if enabled.

Optional Feature:
- Macro: DPRAM_ARB_CLEAR_EN.
- Defined:
  - Reset enters CLEAR with counter=0 and ready=0.
  - Each cycle drives ram_wren=1, ram_addr=counter, ram_data=CLEAR_VALUE, then increments the counter.
  - After the address 2**ADDR_W-1 write is presented, the next cycle enters RUN with ready=1.
  - No acks during CLEAR; requests are held. The first ack can occur the cycle after ready rises.
- Not defined:
  - Reset enters RUN directly.
  - ready<=1 on the first edge after reset deasserts.
  - Arbitration is active from that same edge, so the first ack appears in that cycle.

Test Plan:
- Single read: r0 read addr 7x05 (RAM preloaded 0xA5) -> r0_ack in cycle T, r0_rvalid in T+1 with r0_rdata=0xA5, no r1 activity.
- Contention: r0 and r1 both read from reset (addr 0x10 and 0x20) -> r0 acked first, r1 next cycle; rvalid pulses in order r0, r1 with the matching data.
- Round-robin fairness: both hold req continuously for 8 commands -> acks alternate r0,r1,r0,... and each requester gets 4.
- Write-then-read: r1 writes 0x3C to 0x7F, then reads 0x7F -> r1_rvalid with 0x3C; no rvalid for the write.
- Reset mid-read: assert reset in the cycle of r0_ack -> no r0_rvalid afterwards; all outputs 0 during reset.
- With DPRAM_ARB_CLEAR_EN: release reset with r0_req high -> 128 consecutive ram_wren cycles over addresses 0..127 with data 0x00, ready rises, then r0_ack; a read of 0x55 returns 0x00.
